// File: rtl/conv3x3_engine.sv
// Streaming 3x3 convolution between two block-RAM ports: one scan position per clock,
// runtime taps, valid/same padding, arithmetic scaling and optional 0..255 clamping.
module conv3x3_engine #(
   parameter int          IMG_WIDTH  = 18,
   parameter int          IMG_HEIGHT = 18,
   parameter logic [31:0] IN_BASE    = 32'h0000_0000,
   parameter logic [31:0] OUT_BASE   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [71:0] coef,
   input  logic [3:0]  shift,
   input  logic        sat_en,
   input  logic        same_mode,
   output logic        done,
   output logic        bram0_en,
   output logic [31:0] bram0_addr,
   input  logic [31:0] bram0_dout,
   output logic [3:0]  bram1_we,
   output logic [31:0] bram1_addr,
   output logic [31:0] bram1_din
);

   localparam int CW = $clog2(IMG_WIDTH + 1);
   localparam int RW = $clog2(IMG_HEIGHT + 1);
   localparam logic [CW-1:0] W_C  = CW'(IMG_WIDTH);
   localparam logic [CW-1:0] W_M1 = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] H_C  = RW'(IMG_HEIGHT);
   localparam logic [RW-1:0] H_M1 = RW'(IMG_HEIGHT - 1);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

   state_t        state_q;
   logic [RW-1:0] i_q;
   logic [CW-1:0] j_q;
   logic [1:0]    drain_q;
   logic [71:0]   coef_q;
   logic [3:0]    shift_q;
   logic          sat_q;
   logic          same_q;
   logic          bram0_en_q;
   logic [31:0]   bram0_addr_q;
   logic          done_q;

   logic [RW-1:0] i_last_d, i_nxt_d;
   logic [CW-1:0] j_last_d, j_nxt_d;
   logic          scan_end_d, nxt_img_d, out_d;

   logic          v1_q, img1_q, out1_q, up1_ok_q, up2_ok_q, lmask1_q;
   logic [CW-1:0] j1_q;
   logic [7:0]    pix_d, up1_d, up2_d;
   logic [7:0]    lb0_q [0:IMG_WIDTH];
   logic [7:0]    lb1_q [0:IMG_WIDTH];
   logic [7:0]    win_q [0:8];
   logic          v2_q, lmask2_q;

   logic [20:0]        sum_d;
   logic signed [20:0] shr_d;
   logic [31:0]        res_d;

   logic [3:0]    bram1_we_q;
   logic [31:0]   bram1_addr_q;
   logic [31:0]   bram1_din_q;
   logic [29:0]   n_q;

   logic          unused_dout_s;
   assign unused_dout_s = ^bram0_dout[31:8];

   // Raster stepping over the virtual grid; same mode adds one padding row and column.
   always_comb begin
      i_last_d = same_q ? H_C : H_M1;
      j_last_d = same_q ? W_C : W_M1;
      if (j_q == j_last_d) begin
         j_nxt_d = {CW{1'b0}};
         i_nxt_d = i_q + RW'(1);
      end else begin
         j_nxt_d = j_q + CW'(1);
         i_nxt_d = i_q;
      end
      scan_end_d = (i_q == i_last_d) && (j_q == j_last_d);
      nxt_img_d  = (i_nxt_d < H_C) && (j_nxt_d < W_C);
      if (same_q) begin
         out_d = (i_q >= RW'(1)) && (j_q >= CW'(1));
      end else begin
         out_d = (i_q >= RW'(2)) && (j_q >= CW'(2));
      end
   end

   // Control FSM: config capture, scan counters, read port and done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         i_q          <= {RW{1'b0}};
         j_q          <= {CW{1'b0}};
         drain_q      <= 2'd0;
         coef_q       <= 72'd0;
         shift_q      <= 4'd0;
         sat_q        <= 1'b0;
         same_q       <= 1'b0;
         bram0_en_q   <= 1'b0;
         bram0_addr_q <= 32'd0;
         done_q       <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  coef_q       <= coef;
                  shift_q      <= shift;
                  sat_q        <= sat_en;
                  same_q       <= same_mode;
                  i_q          <= {RW{1'b0}};
                  j_q          <= {CW{1'b0}};
                  drain_q      <= 2'd0;
                  bram0_en_q   <= 1'b1;
                  bram0_addr_q <= IN_BASE;
                  state_q      <= S_SCAN;
               end else begin
                  bram0_en_q <= 1'b0;
               end
            end
            S_SCAN: begin
               if (scan_end_d) begin
                  bram0_en_q <= 1'b0;
                  drain_q    <= 2'd0;
                  state_q    <= S_DRAIN;
               end else begin
                  i_q        <= i_nxt_d;
                  j_q        <= j_nxt_d;
                  bram0_en_q <= nxt_img_d;
                  // In-image reads are consecutive pixels, so the address just steps.
                  if (nxt_img_d) begin
                     bram0_addr_q <= bram0_addr_q + 32'd4;
                  end
               end
            end
            S_DRAIN: begin
               bram0_en_q <= 1'b0;
               if (drain_q == 2'd2) begin
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  drain_q <= drain_q + 2'd1;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               done_q     <= 1'b0;
               bram0_en_q <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   // Stage 1: remember what the read in flight means for the window update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q     <= 1'b0;
         img1_q   <= 1'b0;
         out1_q   <= 1'b0;
         up1_ok_q <= 1'b0;
         up2_ok_q <= 1'b0;
         lmask1_q <= 1'b0;
         j1_q     <= {CW{1'b0}};
      end else begin
         v1_q     <= (state_q == S_SCAN);
         img1_q   <= (state_q == S_SCAN) && bram0_en_q;
         out1_q   <= (state_q == S_SCAN) && out_d;
         up1_ok_q <= (i_q >= RW'(1));
         up2_ok_q <= (i_q >= RW'(2));
         lmask1_q <= (j_q == CW'(1));
         j1_q     <= j_q;
      end
   end

   // New window column: rows above come from the line buffers, masked above the image.
   always_comb begin
      pix_d = img1_q   ? bram0_dout[7:0] : 8'd0;
      up1_d = up1_ok_q ? lb0_q[j1_q]     : 8'd0;
      up2_d = up2_ok_q ? lb1_q[j1_q]     : 8'd0;
   end

   // Stage 2: line buffers and the 3x3 window, oldest column on the left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k <= IMG_WIDTH; k++) begin
            lb0_q[k] <= 8'd0;
            lb1_q[k] <= 8'd0;
         end
         for (int k = 0; k < 9; k++) begin
            win_q[k] <= 8'd0;
         end
         v2_q     <= 1'b0;
         lmask2_q <= 1'b0;
      end else begin
         if (v1_q) begin
            lb1_q[j1_q] <= lb0_q[j1_q];
            lb0_q[j1_q] <= pix_d;
            for (int r = 0; r < 3; r++) begin
               win_q[3*r]   <= win_q[3*r+1];
               win_q[3*r+1] <= win_q[3*r+2];
            end
            win_q[2] <= up2_d;
            win_q[5] <= up1_d;
            win_q[8] <= pix_d;
         end
         v2_q     <= out1_q;
         lmask2_q <= lmask1_q;
      end
   end

   // MAC, shift and clamp; at column 1 the left window column is left of the image.
   always_comb begin
      sum_d = 21'd0;
      for (int k = 0; k < 9; k++) begin
         sum_d = sum_d + ((lmask2_q && ((k % 3) == 0)) ? 21'd0 :
                 ({{13{coef_q[8*k+7]}}, coef_q[8*k +: 8]} * {13'd0, win_q[k]}));
      end
      shr_d = $signed(sum_d) >>> shift_q;
      if (!sat_q) begin
         res_d = {{11{shr_d[20]}}, shr_d};
      end else if (shr_d[20]) begin
         res_d = 32'd0;
      end else if (shr_d > 21'sd255) begin
         res_d = 32'd255;
      end else begin
         res_d = {24'd0, shr_d[7:0]};
      end
   end

   // Stage 3: registered write port and output index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bram1_we_q   <= 4'h0;
         bram1_addr_q <= 32'd0;
         bram1_din_q  <= 32'd0;
         n_q          <= 30'd0;
      end else begin
         if ((state_q == S_IDLE) && start) begin
            n_q <= 30'd0;
         end else if (v2_q) begin
            n_q <= n_q + 30'd1;
         end
         bram1_we_q <= v2_q ? 4'hF : 4'h0;
         if (v2_q) begin
            bram1_addr_q <= OUT_BASE + {n_q, 2'b00};
            bram1_din_q  <= res_d;
         end
      end
   end

   assign done       = done_q;
   assign bram0_en   = bram0_en_q;
   assign bram0_addr = bram0_addr_q;
   assign bram1_we   = bram1_we_q;
   assign bram1_addr = bram1_addr_q;
   assign bram1_din  = bram1_din_q;

endmodule

// File: doc/conv3x3_engine.md
# conv3x3_engine

Parametrised 3x3 2-D convolution engine that streams a grayscale image from the input BRAM (port 0) and writes filtered pixels to the output BRAM (port 1). It adds runtime-loadable signed coefficients, valid/same padding, arithmetic output scaling and optional saturation, and configurable BRAM base addresses. It sits between the two block-RAM ports under a start/done control handshake and sustains one output pixel per clock.

## Interface
- IMG_WIDTH, 18: image width W in pixels, ≥3
- IMG_HEIGHT, 18: image height H in pixels, ≥3
- IN_BASE, 0: byte address of input pixel (0,0) in BRAM0
- OUT_BASE, 0: byte address of first output word in BRAM1
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start pulse, sampled in IDLE only
- coef  in  72  nine signed 8-bit taps; coef[8k+7:8k] = tap k, k = 3*dy+dx, dy,dx ∈ {0,1,2}, (0,0) top-left
- shift  in  4  arithmetic right shift applied to the sum, 0..15
- sat_en  in  1  1: clamp result to 0..255; 0: full signed result
- same_mode  in  1  1: zero-padded HxW output; 0: valid (H-2)x(W-2) output
- done  out  1  one-cycle pulse when the last output word has been written
- bram0_en  out  1  read enable to BRAM0
- bram0_addr  out  32  BRAM0 byte address
- bram0_dout  in  32  BRAM0 data, valid the cycle after bram0_en
- bram1_we  out  4  BRAM1 byte write enables, 4'hF or 4'h0
- bram1_addr  out  32  BRAM1 byte address
- bram1_din  out  32  BRAM1 write data

## Operation
- States: IDLE → SCAN → DRAIN → DONE → IDLE.
- IDLE: start=1 latches coef, shift, sat_en, same_mode; clears counters; → SCAN. Inputs ignored outside IDLE.
- SCAN walks a virtual grid in raster order, one position (i,j) per cycle: valid mode i∈[0,H-1], j∈[0,W-1]; same mode i∈[0,H], j∈[0,W].
- For i<H and j<W: bram0_en=1, bram0_addr = IN_BASE + 4*(i*W+j). Pixel = bram0_dout[7:0], unsigned; upper bits ignored. Other positions inject pixel 0 without a read.
- Two line buffers of W pixels plus a 3x3 window register. Any tap outside the image (row/col <0 or ≥ H/W) contributes 0.
- Output produced for position (i,j) when i≥2, j≥2 (valid) or i≥1, j≥1 (same); window centred at (i-1,j-1).
- sum = Σ tap_k × pixel_k, 21-bit signed; r = sum >>> shift (arithmetic).
- sat_en=1: bram1_din = {24'b0, clamp(r,0,255)}. sat_en=0: bram1_din = r sign-extended to 32 bits.
- Output index n counts 0.. in raster order of the output image; bram1_addr = OUT_BASE + 4*n. Valid: n ≤ (H-2)(W-2)-1; same: n ≤ H*W-1.
- After the last scan position → DRAIN until the last write retires → DONE (done=1 for one cycle) → IDLE.
- No BRAM0 reads or BRAM1 writes outside SCAN/DRAIN.

## Timing
- Reset values: done=0, bram0_en=0, bram0_addr=0, bram1_we=0, bram1_addr=0, bram1_din=0; state IDLE, counters 0.
- Reset asserted mid-operation: outputs return to reset values immediately; no write completes after the reset edge; next start restarts from (0,0).
- Position (i,j) scanned in cycle t → its write (if any) has bram1_we=4'hF in cycle t+3. Pipeline: t read, t+1 data/window, t+2 MAC register, t+3 write.
- Throughput one position per cycle, no stalls, no bubbles at row boundaries.
- First scan cycle is the cycle after start is sampled.
- done high in cycle L+1, where L = cycle of the last write. Scan length: valid H*W cycles; same (H+1)(W+1) cycles.
- start asserted during SCAN/DRAIN/DONE: ignored, no effect on config or counters.
- Back-to-back: start accepted in the first IDLE cycle after DONE.

## Test plan
- Identity (tap4=1, others 0), shift 0, sat_en=1, valid, 18x18, pixel(r,c)=(18r+c)&255 → 256 writes, word n = pixel(n/16+1, n%16+1); done one cycle after write 255; exactly 324 bram0_en cycles.
- All taps 1, same mode, constant image 10, sat_en=0 → 324 writes; corners 40, edges 60, interior 90; bram1 words beyond OUT_BASE+4*323 untouched.
- All taps 127, pixels 255, shift 0: sat_en=0 → every word 0x00047289; sat_en=1 → 0x000000FF. All taps -128: sat_en=0 → 0xFFFB8480; sat_en=1 → 0x00000000.
- tap4=16, shift=4, pixel 200, sat_en=0 → 200; tap4=-16, shift=4 → 0xFFFFFF38 (-200); tap4=1, pixel 3, shift=1 → 1.
- start re-pulsed mid-scan with different coef → ignored, results match first config; rst_n low mid-scan for 2 cycles → all outputs 0, no done; fresh start → full correct output.
- OUT_BASE=0x100, IN_BASE=0x400, 242x182 valid → first write addr 0x100, last 0x100+4*(240*180-1); total cycles start-to-done = 242*182+4.
